// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd_pkg : shared types and constants for bin_to_bcd_seq       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int             DIGIT_W     = 4;
  localparam logic [3:0]     ADD3_THRESH = 4'd5;

endpackage : bin_to_bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_add3_digit : double-dabble correction, adds 3 to a digit >= 5    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_add3_digit
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3_digit
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd_seq : sequential shift-and-add-3 binary to BCD converter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [WIDTH-1:0]            bin_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [DIGIT_W*DIGITS-1:0]   bcd_o,
  output logic                        overflow_o
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   bin_q,     bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               overflow_q, overflow_d;
  logic [BCD_W-1:0]   adj;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_add3_digit u_add3 (
        .digit_i (scratch_q[k*DIGIT_W +: DIGIT_W]),
        .digit_o (adj[k*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d     = bin_i;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The MSB of the corrected top digit leaves the register: that is a lost carry.
        scratch_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          bcd_d      = scratch_d;
          overflow_d = ovf_acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o     = (state_q == SHIFT);
  assign done_o     = (state_q == DONE);
  assign bcd_o      = bcd_q;
  assign overflow_o = overflow_q;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : directed bench for 3-digit and 2-digit instances |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
    .busy_o(busy3), .done_o(done3), .bcd_o(bcd3), .overflow_o(ovf3)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
    .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .overflow_o(ovf2)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the done cycle.
  task automatic run_conv(input logic [7:0] b, input logic [11:0] e3,
                          input logic [7:0] e2, input logic o2, input string tag);
    int  busy_cnt;
    logic got;
    busy_cnt = 0;
    got      = 1'b0;
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    bin   = ~b;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (done3) got = 1'b1;
      else if (busy3) busy_cnt++;
    end
    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, " done2"}, 32'(done2), 32'd1);
    chk({tag, " bcd3"}, 32'(bcd3), 32'(e3));
    chk({tag, " ovf3"}, 32'(ovf3), 32'd0);
    chk({tag, " bcd2"}, 32'(bcd2), 32'(e2));
    chk({tag, " ovf2"}, 32'(ovf2), 32'(o2));
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'({done3, busy3}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    vecs[0] = '{8'd0,   12'h000, 8'h00, 1'b0};
    vecs[1] = '{8'd9,   12'h009, 8'h09, 1'b0};
    vecs[2] = '{8'd10,  12'h010, 8'h10, 1'b0};
    vecs[3] = '{8'd255, 12'h255, 8'h55, 1'b1};
    vecs[4] = '{8'd99,  12'h099, 8'h99, 1'b0};
    vecs[5] = '{8'd100, 12'h100, 8'h00, 1'b1};
    vecs[6] = '{8'd123, 12'h123, 8'h23, 1'b1};
    vecs[7] = '{8'd200, 12'h200, 8'h00, 1'b1};

    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 8'hFF;
    @(negedge clk);
    chk("reset busy/done", 32'({busy3, done3, busy2, done2}), 32'd0);
    chk("reset bcd3", 32'(bcd3), 32'd0);
    chk("reset bcd2/ovf", 32'({bcd2, ovf2, ovf3}), 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    for (int v = 0; v < 8; v++)
      run_conv(vecs[v].bin, vecs[v].bcd3, vecs[v].bcd2, vecs[v].ovf2,
               $sformatf("vec%0d", v));

    for (int b = 0; b < 256; b++) begin
      logic [11:0] e3;
      logic [7:0]  e2;
      e3 = {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
      e2 = {4'((b / 10) % 10), 4'(b % 10)};
      run_conv(8'(b), e3, e2, (b >= 100), $sformatf("sweep%0d", b));
    end

    // start and bin toggled throughout SHIFT must be ignored
    done_cnt = 0;
    start = 1'b1;
    bin   = 8'd123;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done3) begin
        done_cnt++;
        chk("ign bcd3", 32'(bcd3), 32'h123);
        chk("ign bcd2", 32'({bcd2, ovf2}), 32'({8'h23, 1'b1}));
        start = 1'b0;
      end else if (done_cnt == 0) begin
        start = 1'b1;
        bin   = 8'($urandom);
      end else begin
        chk("ign no restart", 32'(busy3), 32'd0);
      end
    end
    chk("ign done count", 32'(done_cnt), 32'd1);

    // reset four cycles into a conversion of 200
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy before rst", 32'(busy3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy/done", 32'({busy3, done3, busy2, done2}), 32'd0);
    chk("abort bcd3", 32'(bcd3), 32'h000);
    chk("abort bcd2/ovf", 32'({bcd2, ovf2}), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done3 || busy3) done_cnt++;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    run_conv(8'd200, 12'h200, 8'h00, 1'b1, "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
